// File: rtl/mxrv_pkg.sv
// Shared RV32/RV64 base-ISA decode constants and the decoded-bundle layout
// used by the instruction-decode pipe.
package mxrv_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_PRIV = 3'b000;
    localparam logic [2:0] F3_RSVD = 3'b100;

    typedef enum logic [2:0] {
        IT_R    = 3'd0,
        IT_I    = 3'd1,
        IT_S    = 3'd2,
        IT_B    = 3'd3,
        IT_U    = 3'd4,
        IT_J    = 3'd5,
        IT_NONE = 3'd6
    } itype_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        itype_e     itype;
        logic       rd_we;
        logic       rs1_re;
        logic       rs2_re;
        logic       mext;
        logic       illegal;
    } dec_fields_t;

endpackage

// File: rtl/mxrv_id_dec.sv
// Pure combinational RISC-V base-ISA decoder for one 32-bit instruction.
// Define MXRV_ID_M_EXT_EN to accept the M-extension (OP, funct7=0000001).
module mxrv_id_dec import mxrv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output dec_fields_t     fields,
    output logic [XLEN-1:0] imm
);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       shamt_hi_bad;
    itype_e     fmt;
    logic       legal;
    logic       wr;
    logic       rd1;
    logic       rd2;
    logic       mx;

    assign f3 = inst[14:12];
    assign f7 = inst[31:25];
    // On RV32 the shift amount is only 5 bits, so inst[25] must be clear.
    assign shamt_hi_bad = (XLEN == 32) && inst[25];

    always_comb begin
        fmt   = IT_NONE;
        legal = 1'b0;
        wr    = 1'b0;
        rd1   = 1'b0;
        rd2   = 1'b0;
        mx    = 1'b0;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin fmt = IT_U; legal = 1'b1; wr = 1'b1; end
            OPC_JAL:            begin fmt = IT_J; legal = 1'b1; wr = 1'b1; end
            OPC_JALR: begin
                fmt = IT_I; wr = 1'b1; rd1 = 1'b1;
                legal = (f3 == F3_ADD);
            end
            OPC_BRANCH: begin
                fmt = IT_B; rd1 = 1'b1; rd2 = 1'b1;
                legal = (f3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                fmt = IT_I; wr = 1'b1; rd1 = 1'b1;
                legal = (f3 != 3'b111) && ((XLEN == 64) || (f3 != 3'b011 && f3 != 3'b110));
            end
            OPC_STORE: begin
                fmt = IT_S; rd1 = 1'b1; rd2 = 1'b1;
                legal = !f3[2] && ((XLEN == 64) || (f3 != 3'b011));
            end
            OPC_OPIMM: begin
                fmt = IT_I; wr = 1'b1; rd1 = 1'b1;
                case (f3)
                    F3_SLL:  legal = (inst[31:26] == 6'b000000) && !shamt_hi_bad;
                    F3_SR:   legal = (inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000)
                                     && !shamt_hi_bad;
                    default: legal = 1'b1;
                endcase
            end
            OPC_OP: begin
                fmt = IT_R; wr = 1'b1; rd1 = 1'b1; rd2 = 1'b1;
                if (f7 == F7_ZERO)
                    legal = 1'b1;
                else if (f7 == F7_ALT)
                    legal = (f3 == F3_ADD) || (f3 == F3_SR);
                else if (f7 == F7_MULDIV) begin
`ifdef MXRV_ID_M_EXT_EN
                    legal = 1'b1;
                    mx    = 1'b1;
`else
                    legal = 1'b0;
`endif
                end
            end
            // FENCE / FENCE.I carry no architectural register traffic.
            OPC_MISCMEM: begin
                fmt = IT_I;
                legal = (f3[2:1] == 2'b00);
            end
            OPC_SYSTEM: begin
                fmt = IT_I;
                legal = (f3 != F3_RSVD);
                wr    = (f3 != F3_PRIV);
                rd1   = (f3 != F3_PRIV) && !f3[2];
            end
            default: fmt = IT_NONE;
        endcase
    end

    always_comb begin
        fields        = '0;
        imm           = '0;
        fields.opcode = inst[6:0];
        fields.itype  = fmt;
        case (fmt)
            IT_R: begin
                fields.rd = inst[11:7]; fields.rs1 = inst[19:15]; fields.rs2 = inst[24:20];
                fields.funct3 = f3; fields.funct7 = f7;
            end
            IT_I: begin
                fields.rd = inst[11:7]; fields.rs1 = inst[19:15]; fields.funct3 = f3;
                imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            end
            IT_S: begin
                fields.rs1 = inst[19:15]; fields.rs2 = inst[24:20]; fields.funct3 = f3;
                imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            end
            IT_B: begin
                fields.rs1 = inst[19:15]; fields.rs2 = inst[24:20]; fields.funct3 = f3;
                imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            IT_U: begin
                fields.rd = inst[11:7];
                imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
            end
            IT_J: begin
                fields.rd = inst[11:7];
                imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: fields.rd = 5'd0;
        endcase
        fields.rd_we   = wr && legal && (fields.rd != 5'd0);
        fields.rs1_re  = rd1 && legal;
        fields.rs2_re  = rd2 && legal;
        fields.mext    = mx && legal;
        fields.illegal = !legal;
    end

endmodule

// File: rtl/mxrv_id_pipe.sv
// Instruction-decode stage: decoder on the input side feeding a two-entry
// skid buffer (main + skid). M-extension decode enabled by MXRV_ID_M_EXT_EN.
module mxrv_id_pipe import mxrv_pkg::*; #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic [31:0]     inst_data_i,
    input  logic [PC_W-1:0] inst_pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [PC_W-1:0] dec_pc_o,
    output logic [6:0]      opcode_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      itype_o,
    output logic            rd_we_o,
    output logic            rs1_re_o,
    output logic            rs2_re_o,
    output logic            mext_o,
    output logic            illegal_o
);

    dec_fields_t     in_f;
    logic [XLEN-1:0] in_imm;

    dec_fields_t     main_f_p1;
    dec_fields_t     skid_f_p1;
    logic [XLEN-1:0] main_imm_p1;
    logic [XLEN-1:0] skid_imm_p1;
    logic [PC_W-1:0] main_pc_p1;
    logic [PC_W-1:0] skid_pc_p1;
    logic            main_vld_p1;
    logic            skid_vld_p1;
    logic            rdy_p1;

    logic push, pop;
    logic ld_main_in, ld_main_skid, ld_skid;
    logic main_vld_nxt, skid_vld_nxt;

    mxrv_id_dec #(.XLEN(XLEN)) u_dec (
        .inst   (inst_data_i),
        .fields (in_f),
        .imm    (in_imm)
    );

    assign push = inst_valid_i && rdy_p1;
    assign pop  = main_vld_p1 && dec_ready_i;

    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        main_vld_nxt = main_vld_p1;
        skid_vld_nxt = skid_vld_p1;
        if (!main_vld_p1) begin
            if (push) begin
                ld_main_in   = 1'b1;
                main_vld_nxt = 1'b1;
            end
        end else if (pop) begin
            if (skid_vld_p1) begin
                ld_main_skid = 1'b1;
                skid_vld_nxt = 1'b0;
            end else if (push) begin
                ld_main_in = 1'b1;
            end else begin
                main_vld_nxt = 1'b0;
            end
        end else if (push) begin
            ld_skid      = 1'b1;
            skid_vld_nxt = 1'b1;
        end
    end

    // p0 -> p1: decoded bundle captured into main or skid
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
            main_f_p1   <= '0;
            main_imm_p1 <= '0;
            main_pc_p1  <= '0;
            skid_f_p1   <= '0;
            skid_imm_p1 <= '0;
            skid_pc_p1  <= '0;
        end else if (flush_i) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b1;
        end else begin
            main_vld_p1 <= main_vld_nxt;
            skid_vld_p1 <= skid_vld_nxt;
            rdy_p1      <= !skid_vld_nxt;
            if (ld_main_in) begin
                main_f_p1   <= in_f;
                main_imm_p1 <= in_imm;
                main_pc_p1  <= inst_pc_i;
            end else if (ld_main_skid) begin
                main_f_p1   <= skid_f_p1;
                main_imm_p1 <= skid_imm_p1;
                main_pc_p1  <= skid_pc_p1;
            end
            if (ld_skid) begin
                skid_f_p1   <= in_f;
                skid_imm_p1 <= in_imm;
                skid_pc_p1  <= inst_pc_i;
            end
        end
    end

    assign inst_ready_o = rdy_p1;
    assign dec_valid_o  = main_vld_p1;
    assign dec_pc_o     = main_pc_p1;
    assign opcode_o     = main_f_p1.opcode;
    assign rd_o         = main_f_p1.rd;
    assign rs1_o        = main_f_p1.rs1;
    assign rs2_o        = main_f_p1.rs2;
    assign funct3_o     = main_f_p1.funct3;
    assign funct7_o     = main_f_p1.funct7;
    assign imm_o        = main_imm_p1;
    assign itype_o      = main_f_p1.itype;
    assign rd_we_o      = main_f_p1.rd_we;
    assign rs1_re_o     = main_f_p1.rs1_re;
    assign rs2_re_o     = main_f_p1.rs2_re;
    assign mext_o       = main_f_p1.mext;
    assign illegal_o    = main_f_p1.illegal;

endmodule

// File: tb/tb_mxrv_id_pipe.sv
// Bench for mxrv_id_pipe: queue-based reference model plus directed vectors
// with hand-computed expectations. Honours MXRV_ID_M_EXT_EN like the design.
module tb_mxrv_id_pipe;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4, T_J = 3'd5, T_NONE = 3'd6;

    logic            clk;
    logic            rst;
    logic            flush_i;
    logic            inst_valid_i;
    logic            inst_ready_o;
    logic [31:0]     inst_data_i;
    logic [PC_W-1:0] inst_pc_i;
    logic            dec_valid_o;
    logic            dec_ready_i;
    logic [PC_W-1:0] dec_pc_o;
    logic [6:0]      opcode_o;
    logic [4:0]      rd_o, rs1_o, rs2_o;
    logic [2:0]      funct3_o;
    logic [6:0]      funct7_o;
    logic [XLEN-1:0] imm_o;
    logic [2:0]      itype_o;
    logic            rd_we_o, rs1_re_o, rs2_re_o, mext_o, illegal_o;

    mxrv_id_pipe #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_data_i(inst_data_i), .inst_pc_i(inst_pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_pc_o(dec_pc_o), .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o),
        .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .imm_o(imm_o),
        .itype_o(itype_o), .rd_we_o(rd_we_o), .rs1_re_o(rs1_re_o),
        .rs2_re_o(rs2_re_o), .mext_o(mext_o), .illegal_o(illegal_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [2:0]  itype;
        logic        rd_we, rs1_re, rs2_re, mext, illegal;
    } exp_t;

    exp_t        q[$];
    logic [31:0] seen_pc[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          chk_en = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA tables: format, legality and the
    // immediate built with arithmetic on the sign-extended instruction word.
    function automatic exp_t model_dec(input logic [31:0] w, input logic [31:0] a);
        exp_t        e;
        longint      sw;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  fmt;
        bit          ok, wr, r1, r2, mx;
        e  = '{default: '0};
        sw = longint'($signed(w));
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 0; wr = 0; r1 = 0; r2 = 0; mx = 0; fmt = T_NONE;
        case (w[6:0])
            7'h37, 7'h17: begin fmt = T_U; ok = 1; wr = 1; end
            7'h6F: begin fmt = T_J; ok = 1; wr = 1; end
            7'h67: begin fmt = T_I; ok = (f3 == 3'd0); wr = 1; r1 = 1; end
            7'h63: begin fmt = T_B; ok = !(f3 inside {3'd2, 3'd3}); r1 = 1; r2 = 1; end
            7'h03: begin fmt = T_I; ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; wr = 1; r1 = 1; end
            7'h23: begin fmt = T_S; ok = f3 inside {3'd0, 3'd1, 3'd2}; r1 = 1; r2 = 1; end
            7'h13: begin
                fmt = T_I; wr = 1; r1 = 1;
                if (f3 == 3'd1)      ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                else                 ok = 1;
            end
            7'h33: begin
                fmt = T_R; wr = 1; r1 = 1; r2 = 1;
                ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
`ifdef MXRV_ID_M_EXT_EN
                if (f7 == 7'h01) begin ok = 1; mx = 1; end
`endif
            end
            7'h0F: begin fmt = T_I; ok = f3 inside {3'd0, 3'd1}; end
            7'h73: begin fmt = T_I; ok = (f3 != 3'd4); wr = (f3 != 3'd0); r1 = f3 inside {3'd1, 3'd2, 3'd3}; end
            default: fmt = T_NONE;
        endcase
        e.pc     = a;
        e.opcode = w[6:0];
        e.itype  = fmt;
        if (fmt inside {T_R, T_I, T_U, T_J}) e.rd = w[11:7];
        if (fmt inside {T_R, T_I, T_S, T_B}) begin e.rs1 = w[19:15]; e.f3 = f3; end
        if (fmt inside {T_R, T_S, T_B}) e.rs2 = w[24:20];
        if (fmt == T_R) e.f7 = f7;
        case (fmt)
            T_I: e.imm = sw >>> 20;
            T_S: e.imm = ((sw >>> 25) <<< 5) | longint'(w[11:7]);
            T_B: e.imm = ((sw >>> 31) <<< 12) | (longint'(w[7]) << 11)
                         | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
            T_U: e.imm = longint'($signed(w & 32'hFFFFF000));
            T_J: e.imm = ((sw >>> 31) <<< 20) | (longint'(w[19:12]) << 12)
                         | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
            default: e.imm = 64'd0;
        endcase
        e.illegal = !ok;
        e.rd_we   = ok && wr && (e.rd != 5'd0);
        e.rs1_re  = ok && r1;
        e.rs2_re  = ok && r2;
        e.mext    = ok && mx;
        return e;
    endfunction

    always @(posedge clk) begin : model_blk
        bit pop, push;
        if (rst || flush_i) begin
            q.delete();
        end else begin
            pop  = (q.size() > 0) && dec_ready_i;
            push = inst_valid_i && (q.size() < 2);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(model_dec(inst_data_i, inst_pc_i));
        end
    end

    always @(negedge clk) begin : chk_blk
        exp_t e;
        if (chk_en) begin
            cmp("dec_valid", 64'(dec_valid_o), 64'(q.size() > 0));
            cmp("inst_ready", 64'(inst_ready_o), 64'(q.size() < 2));
            if (q.size() > 0) begin
                e = q[0];
                cmp("pc", 64'(dec_pc_o), 64'(e.pc));
                cmp("opcode", 64'(opcode_o), 64'(e.opcode));
                cmp("rd", 64'(rd_o), 64'(e.rd));
                cmp("rs1", 64'(rs1_o), 64'(e.rs1));
                cmp("rs2", 64'(rs2_o), 64'(e.rs2));
                cmp("funct3", 64'(funct3_o), 64'(e.f3));
                cmp("funct7", 64'(funct7_o), 64'(e.f7));
                cmp("imm", 64'(imm_o), 64'(e.imm[XLEN-1:0]));
                cmp("itype", 64'(itype_o), 64'(e.itype));
                cmp("rd_we", 64'(rd_we_o), 64'(e.rd_we));
                cmp("rs1_re", 64'(rs1_re_o), 64'(e.rs1_re));
                cmp("rs2_re", 64'(rs2_re_o), 64'(e.rs2_re));
                cmp("mext", 64'(mext_o), 64'(e.mext));
                cmp("illegal", 64'(illegal_o), 64'(e.illegal));
            end
            if (dec_valid_o && dec_ready_i) seen_pc.push_back(dec_pc_o);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] w, input logic [31:0] a);
        bit r, acc;
        acc = 0;
        inst_valid_i = 1'b1;
        inst_data_i  = w;
        inst_pc_i    = a;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            r = inst_ready_o;
            @(posedge clk);
            #1;
            if (r) begin acc = 1; break; end
        end
        inst_valid_i = 1'b0;
        if (!acc) begin
            miscompares++;
            $display("FAIL send_timeout: pc 0x%0h never accepted", a);
        end
    endtask

    task automatic single(input logic [31:0] w, input logic [31:0] a);
        dec_ready_i = 1'b1;
        send(w, a);
        @(negedge clk);
    endtask

    logic [31:0] prog [18];
    logic [15:0] rpat;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog = '{32'h123450B7, 32'h00001117, 32'h000080E7, 32'hFE208EE3,
                 32'h0040A183, 32'h0030A423, 32'h00209093, 32'h4020D093,
                 32'h0220D093, 32'h402081B3, 32'h4020A1B3, 32'h0FF0000F,
                 32'h34011073, 32'h00000073, 32'h00004073, 32'h00000013,
                 32'h00000012, 32'h0000005B};
        rpat = 16'b1011_0011_1000_1101;
        rst = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0;
        inst_data_i = '0; inst_pc_i = '0; dec_ready_i = 1'b0;

        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        cmp("rst_dec_valid", 64'(dec_valid_o), 64'd0);
        cmp("rst_inst_ready", 64'(inst_ready_o), 64'd1);
        cmp("rst_imm", 64'(imm_o), 64'd0);
        cmp("rst_rd", 64'(rd_o), 64'd0);
        cmp("rst_pc", 64'(dec_pc_o), 64'd0);
        cmp("rst_illegal", 64'(illegal_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        single(32'hFFF10093, 32'h100);
        cmp("addi_valid", 64'(dec_valid_o), 64'd1);
        cmp("addi_pc", 64'(dec_pc_o), 64'h100);
        cmp("addi_imm", 64'(imm_o), 64'hFFFFFFFF);
        cmp("addi_rd", 64'(rd_o), 64'd1);
        cmp("addi_rs1", 64'(rs1_o), 64'd2);
        cmp("addi_itype", 64'(itype_o), 64'(T_I));
        cmp("addi_rd_we", 64'(rd_we_o), 64'd1);
        @(posedge clk); #1;

        single(32'hFFDFF0EF, 32'h104);
        cmp("jal_imm", 64'(imm_o), 64'hFFFFFFFC);
        cmp("jal_itype", 64'(itype_o), 64'(T_J));
        cmp("jal_rs1_re", 64'(rs1_re_o), 64'd0);
        cmp("jal_rd", 64'(rd_o), 64'd1);
        @(posedge clk); #1;

        single(32'h00000000, 32'h108);
        cmp("zero_illegal", 64'(illegal_o), 64'd1);
        cmp("zero_rd_we", 64'(rd_we_o), 64'd0);
        cmp("zero_itype", 64'(itype_o), 64'(T_NONE));
        @(posedge clk); #1;

        single(32'h022081B3, 32'h10C);
        cmp("mul_rd", 64'(rd_o), 64'd3);
        cmp("mul_rs1", 64'(rs1_o), 64'd1);
        cmp("mul_rs2", 64'(rs2_o), 64'd2);
`ifdef MXRV_ID_M_EXT_EN
        cmp("mul_illegal", 64'(illegal_o), 64'd0);
        cmp("mul_mext", 64'(mext_o), 64'd1);
`else
        cmp("mul_illegal", 64'(illegal_o), 64'd1);
        cmp("mul_mext", 64'(mext_o), 64'd0);
`endif
        @(posedge clk); #1;

        // Three back-to-back inputs against a stalled consumer.
        dec_ready_i = 1'b0;
        fork
            begin
                send(32'h00100093, 32'h200);
                send(32'h00200113, 32'h204);
                @(negedge clk);
                cmp("b2b_ready_drop", 64'(inst_ready_o), 64'd0);
                cmp("b2b_valid", 64'(dec_valid_o), 64'd1);
                @(posedge clk); #1;
                send(32'h00300193, 32'h208);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                dec_ready_i = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        if (seen_pc.size() >= 3) begin
            cmp("b2b_order0", 64'(seen_pc[seen_pc.size()-3]), 64'h200);
            cmp("b2b_order1", 64'(seen_pc[seen_pc.size()-2]), 64'h204);
            cmp("b2b_order2", 64'(seen_pc[seen_pc.size()-1]), 64'h208);
        end else begin
            cmp("b2b_count", 64'(seen_pc.size()), 64'd3);
        end

        // Mixed formats with an irregular consumer.
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    send(prog[i], 32'h400 + 32'(4 * i));
                    if (i % 3 == 2) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    dec_ready_i = rpat[c % 16];
                    @(posedge clk); #1;
                end
                dec_ready_i = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        cmp("stream_drained", 64'(dec_valid_o), 64'd0);
        @(posedge clk); #1;

        // Flush with both entries occupied.
        dec_ready_i = 1'b0;
        send(32'h00A00513, 32'h500);
        send(32'h00B00593, 32'h504);
        @(negedge clk);
        cmp("flush_pre_ready", 64'(inst_ready_o), 64'd0);
        cmp("flush_pre_valid", 64'(dec_valid_o), 64'd1);
        @(posedge clk); #1;
        flush_i = 1'b1; inst_valid_i = 1'b1;
        inst_data_i = 32'h00C00613; inst_pc_i = 32'h508;
        @(posedge clk); #1;
        flush_i = 1'b0; inst_valid_i = 1'b0; dec_ready_i = 1'b1;
        @(negedge clk);
        cmp("flush_valid", 64'(dec_valid_o), 64'd0);
        cmp("flush_ready", 64'(inst_ready_o), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        // Flush while ready is high: the flush-cycle input is dropped.
        dec_ready_i = 1'b0;
        send(32'h00D00693, 32'h600);
        flush_i = 1'b1; inst_valid_i = 1'b1;
        inst_data_i = 32'h000052B7; inst_pc_i = 32'h604;
        @(posedge clk); #1;
        flush_i = 1'b0; inst_valid_i = 1'b0; dec_ready_i = 1'b1;
        @(negedge clk);
        cmp("flush_drop_valid", 64'(dec_valid_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-stall wins over flush and a pending input.
        dec_ready_i = 1'b0;
        send(32'hFFF00713, 32'h700);
        send(32'h0000F7B7, 32'h704);
        rst = 1'b1; flush_i = 1'b1; inst_valid_i = 1'b1;
        inst_data_i = 32'h00100813; inst_pc_i = 32'h708;
        @(posedge clk); #1;
        rst = 1'b0; flush_i = 1'b0; inst_valid_i = 1'b0;
        @(negedge clk);
        cmp("rst2_valid", 64'(dec_valid_o), 64'd0);
        cmp("rst2_ready", 64'(inst_ready_o), 64'd1);
        cmp("rst2_imm", 64'(imm_o), 64'd0);
        cmp("rst2_rd", 64'(rd_o), 64'd0);
        cmp("rst2_pc", 64'(dec_pc_o), 64'd0);
        cmp("rst2_opcode", 64'(opcode_o), 64'd0);
        @(posedge clk); #1;

        single(32'h00500293, 32'h800);
        cmp("post_rst_imm", 64'(imm_o), 64'd5);
        cmp("post_rst_rd", 64'(rd_o), 64'd5);
        cmp("post_rst_rs1", 64'(rs1_o), 64'd0);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
